bcd_timer_ctrl: RTL and testbench

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

---
 rtl/bcd_timer_pkg.sv | 6 +
 rtl/bcd_digit_dec.sv | 14 +
 rtl/bcd_timer_ctrl.sv | 95 +++++++++
 tb/tb_bcd_timer_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types and constants for the BCD countdown timer.
package bcd_timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit decrement stage with borrow chaining, 0 wraps to 9.
module bcd_digit_dec
    import bcd_timer_pkg::*;
(
    input  logic [3:0] d,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);
    always_comb begin
        q    = bin ? ((d == 4'd0) ? BCD_MAX : d - 4'd1) : d;
        bout = bin && (d == 4'd0);
    end
endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: BCD countdown timer with start/pause/abort control.
// Define BCD_TIMER_AUTO_RELOAD_EN to reload the preset and keep running after each expiry.
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                tick,
    input  logic [4*DIGITS-1:0] preset,
    output logic [4*DIGITS-1:0] q,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t              state;
    logic [DIGITS:0]     borrow;
    logic [4*DIGITS-1:0] q_dec;
    logic [DIGITS-1:0]   ok;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [4*DIGITS-1:0] reload;
`endif
    assign borrow[0] = 1'b1;
    // A borrow out of the top digit means every digit was zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_dec u_dig (
            .d   (q[4*i +: 4]),
            .bin (borrow[i]),
            .q   (q_dec[4*i +: 4]),
            .bout(borrow[i+1])
        );
        assign ok[i] = preset[4*i +: 4] <= BCD_MAX;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && &ok) begin
                        q     <= preset;
                        err   <= 1'b0;
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        reload <= preset;
`endif
                    end else if (start) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    end else if (state == DONE) begin
                        state <= RUN;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) state <= PAUSED;
                    else if (tick && borrow[DIGITS]) begin
                        state <= DONE;
                        done  <= 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        q <= reload;
`else
                        busy <= 1'b0;
`endif
                    end else if (tick) q <= q_dec;
                end
                PAUSED: begin
                    if (stop) begin
                        state <= IDLE;
                        q     <= '0;
                        busy  <= 1'b0;
                    end else if (start) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed self-checking bench for bcd_timer_ctrl (2- and 3-digit instances).
module tb_bcd_timer_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, stop, tick;
    logic [7:0]  preset, q;
    logic        busy, done, err;
    logic        start3, stop3, tick3;
    logic [11:0] preset3, q3;
    logic        busy3, done3, err3;
    int          n_chk = 0, n_fail = 0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic [7:0] seq [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                             8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    always #5 clk = ~clk;

    bcd_timer_ctrl #(.DIGITS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
        .preset(preset), .q(q), .busy(busy), .done(done), .err(err)
    );
    bcd_timer_ctrl #(.DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop(stop3), .tick(tick3),
        .preset(preset3), .q(q3), .busy(busy3), .done(done3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0; preset = 8'h00;
        start3 = 1'b0; stop3 = 1'b0; tick3 = 1'b0; preset3 = 12'h000;
        step;
        rst = 1'b0;
        check("rst_q", q, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        tick = 1'b1; step; tick = 1'b0;
        check("idle_tick_q", q, 8'h00);
        // full countdown from 12
        preset = 8'h12; start = 1'b1; step; start = 1'b0;
        check("load_q", q, 8'h12);
        check("load_busy", busy, 1'b1);
        tick = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step;
            check($sformatf("cnt_%0d", i), q, seq[i]);
            check($sformatf("cnt_done_%0d", i), done, 1'b0);
        end
        step;
        check("expire_done", done, 1'b1);
        check("expire_q", q, AR ? 8'h12 : 8'h00);
        check("expire_busy", busy, AR);
        tick = 1'b0; step;
        check("post_done", done, 1'b0);
        check("post_busy", busy, AR);
        stop = 1'b1; step; step; stop = 1'b0;
        check("idle_q", q, 8'h00);
        check("idle_busy", busy, 1'b0);
        // invalid preset digits
        preset = 8'h1A; start = 1'b1; step; start = 1'b0;
        check("bad_err", err, 1'b1);
        check("bad_busy", busy, 1'b0);
        check("bad_q", q, 8'h00);
        step;
        check("err_hold", err, 1'b1);
        preset = 8'hA0; start = 1'b1; step; start = 1'b0;
        check("bad_hi_err", err, 1'b1);
        preset = 8'h05; start = 1'b1; step;
        check("good_err", err, 1'b0);
        check("good_q", q, 8'h05);
        check("good_busy", busy, 1'b1);
        preset = 8'h40; step; start = 1'b0;
        check("run_start_ign", q, 8'h05);
        // pause with simultaneous tick, then resume
        stop = 1'b1; step; step; stop = 1'b0;
        check("abort_q", q, 8'h00);
        start = 1'b1; step; start = 1'b0;
        check("load40", q, 8'h40);
        stop = 1'b1; tick = 1'b1; step; stop = 1'b0;
        check("pause_q", q, 8'h40);
        check("pause_busy", busy, 1'b1);
        repeat (5) step;
        check("pause_ticks_q", q, 8'h40);
        tick = 1'b0; start = 1'b1; step; start = 1'b0;
        check("resume_q", q, 8'h40);
        check("resume_busy", busy, 1'b1);
        tick = 1'b1; step; tick = 1'b0;
        check("resume_dec", q, 8'h39);
        // abort from pause at 27
        stop = 1'b1; step; stop = 1'b0;
        check("to_pause_q", q, 8'h39);
        stop = 1'b1; step; stop = 1'b0;
        preset = 8'h27; start = 1'b1; step; start = 1'b0;
        stop = 1'b1; step;
        check("p27_q", q, 8'h27);
        check("p27_busy", busy, 1'b1);
        step; stop = 1'b0;
        check("abort27_q", q, 8'h00);
        check("abort27_busy", busy, 1'b0);
        // reset mid-run
        preset = 8'h33; start = 1'b1; step; start = 1'b0;
        check("load33", q, 8'h33);
        rst = 1'b1; tick = 1'b1; step; rst = 1'b0; tick = 1'b0;
        check("midrst_q", q, 8'h00);
        check("midrst_busy", busy, 1'b0);
        step;
        check("midrst_idle_q", q, 8'h00);
        // start+stop together: start wins in IDLE, stop wins in RUN/PAUSED
        preset = 8'h21; start = 1'b1; stop = 1'b1; step;
        check("both_idle_q", q, 8'h21);
        check("both_idle_busy", busy, 1'b1);
        step;
        check("both_run_busy", busy, 1'b1);
        step; start = 1'b0; stop = 1'b0;
        check("both_pause_q", q, 8'h00);
        check("both_pause_busy", busy, 1'b0);
        // three-digit double borrow
        preset3 = 12'h100; start3 = 1'b1; step; start3 = 1'b0;
        check("d3_load", q3, 12'h100);
        tick3 = 1'b1; step; tick3 = 1'b0;
        check("d3_borrow", q3, 12'h099);
        check("d3_busy", busy3, 1'b1);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        preset = 8'h02; start = 1'b1; step; start = 1'b0;
        check("ar_load", q, 8'h02);
        tick = 1'b1;
        step; check("ar_01", q, 8'h01);
        step; check("ar_00", q, 8'h00);
        step;
        check("ar_done", done, 1'b1);
        check("ar_reload", q, 8'h02);
        check("ar_busy", busy, 1'b1);
        step;
        check("ar_done_end", done, 1'b0);
        check("ar_busy2", busy, 1'b1);
        step; tick = 1'b0;
        check("ar_cont", q, 8'h01);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
